// File: rtl/cues_sync_sink.sv
// cues_sync_sink: clocked terminal receiver for a C-element pipeline; 4-phase SENDIN/ACKOUT in, FIFO, valid/ready out.
// Optional macro CUES_SINK_TOKEN_CNT_EN adds a 16-bit accepted-token counter on TOKCNT.
module cues_sync_sink #(
  parameter int DW          = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         CLK,
  input  logic                         RESETN,
  input  logic                         SENDIN,
  input  logic [DW-1:0]                DIN,
  output logic                         ACKOUT,
  output logic [DW-1:0]                DOUT,
  output logic                         DVALID,
  input  logic                         DREADY,
  output logic [$clog2(DEPTH+1)-1:0]   LEVEL
`ifdef CUES_SINK_TOKEN_CNT_EN
  , output logic [15:0]                TOKCNT
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  typedef enum logic {IDLE, ACK} state_t;
  state_t               r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [DW-1:0]        r_mem [DEPTH];
  logic [AW-1:0]        r_wp, r_rp;
  logic [LW-1:0]        r_level;
  logic                 w_send, w_full, w_wr, w_rd;
  assign w_send = r_sync[SYNC_STAGES-1];
  assign w_full = r_level == LW'(DEPTH);
  assign DVALID = r_level != '0;
  assign w_rd   = DVALID && DREADY;
  assign DOUT   = r_mem[r_rp];
  assign LEVEL  = r_level;
  assign ACKOUT = r_state == ACK;
  // Bring the asynchronous request into the clock domain.
  always_ff @(posedge CLK)
    if (!RESETN) r_sync <= '0;
    else r_sync <= {r_sync[SYNC_STAGES-2:0], SENDIN};
  // Handshake state register; ACKOUT is decoded straight from it so it stays glitch-free.
  always_ff @(posedge CLK)
    if (!RESETN) r_state <= IDLE;
    else r_state <= w_next;
  // Accept one token per request; a full FIFO withholds the acknowledge to stall upstream.
  always_comb begin
    w_wr   = 1'b0;
    w_next = r_state;
    if (r_state == IDLE) begin
      w_wr   = w_send && !w_full;
      w_next = w_wr ? ACK : IDLE;
    end else begin
      w_next = w_send ? ACK : IDLE;
    end
  end
  // FIFO storage; data needs no reset because DVALID masks stale entries.
  always_ff @(posedge CLK)
    if (w_wr) r_mem[r_wp] <= DIN;
  // FIFO pointers and occupancy; full is judged before the pop, giving a one-cycle bubble.
  always_ff @(posedge CLK)
    if (!RESETN) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      r_level <= r_level + LW'(w_wr) - LW'(w_rd);
    end
`ifdef CUES_SINK_TOKEN_CNT_EN
  logic [15:0] r_tok;
  assign TOKCNT = r_tok;
  // Count accepted tokens, wrapping naturally at 16 bits.
  always_ff @(posedge CLK)
    if (!RESETN) r_tok <= '0;
    else if (w_wr) r_tok <= r_tok + 16'd1;
`endif
endmodule

// File: tb/tb_cues_sync_sink.sv
// tb_cues_sync_sink: directed self-checking bench for cues_sync_sink.
module tb_cues_sync_sink;
  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       SENDIN = 1'b0;
  logic [7:0] DIN = '0;
  logic       ACKOUT;
  logic [7:0] DOUT;
  logic       DVALID;
  logic       DREADY = 1'b0;
  logic [2:0] LEVEL;
`ifdef CUES_SINK_TOKEN_CNT_EN
  logic [15:0] TOKCNT;
`endif
  int total = 0;
  int bad = 0;
  logic       mon = 1'b0;
  logic [7:0] q [$];
  int         max_lvl = 0;

  cues_sync_sink dut (
    .CLK(CLK), .RESETN(RESETN), .SENDIN(SENDIN), .DIN(DIN), .ACKOUT(ACKOUT),
    .DOUT(DOUT), .DVALID(DVALID), .DREADY(DREADY), .LEVEL(LEVEL)
`ifdef CUES_SINK_TOKEN_CNT_EN
    , .TOKCNT(TOKCNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Record every pop (DREADY held high while mon is set) and the peak occupancy.
  always @(negedge CLK)
    if (mon) begin
      if (DVALID && DREADY) q.push_back(DOUT);
      if (int'(LEVEL) > max_lvl) max_lvl = int'(LEVEL);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    DIN = d;
    SENDIN = 1'b1;
    for (int i = 0; i < 20 && !ACKOUT; i++) tick();
    chk("ack_rise", ACKOUT, 1);
    SENDIN = 1'b0;
    for (int i = 0; i < 20 && ACKOUT; i++) tick();
    chk("ack_fall", ACKOUT, 0);
  endtask

  task automatic pop(input logic [7:0] exp);
    chk("pop_dout", DOUT, exp);
    DREADY = 1'b1;
    tick();
    DREADY = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    RESETN = 1'b1;
    chk("rst_ack", ACKOUT, 0);
    chk("rst_valid", DVALID, 0);
    chk("rst_level", LEVEL, 0);
`ifdef CUES_SINK_TOKEN_CNT_EN
    chk("rst_tok", TOKCNT, 0);
`endif
    DREADY = 1'b1;
    tick();
    DREADY = 1'b0;
    chk("empty_pop_level", LEVEL, 0);

    DIN = 8'hA5;
    SENDIN = 1'b1;
    tick();
    chk("lat_e1_ack", ACKOUT, 0);
    tick();
    chk("lat_e2_ack", ACKOUT, 0);
    chk("lat_e2_valid", DVALID, 0);
    tick();
    chk("lat_e3_ack", ACKOUT, 1);
    chk("lat_e3_valid", DVALID, 1);
    chk("lat_e3_dout", DOUT, 8'hA5);
    chk("lat_e3_level", LEVEL, 1);
    SENDIN = 1'b0;
    tick();
    tick();
    chk("fall_e2_ack", ACKOUT, 1);
    tick();
    chk("fall_e3_ack", ACKOUT, 0);
    pop(8'hA5);
    chk("single_drained", LEVEL, 0);

    for (int i = 1; i <= 4; i++) send(8'(i));
    chk("fill_level", LEVEL, 4);
    chk("fill_head", DOUT, 8'h01);
    DIN = 8'h05;
    SENDIN = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("bp_ack_low", ACKOUT, 0);
    chk("bp_level", LEVEL, 4);
    pop(8'h01);
    chk("bubble_level", LEVEL, 3);
    chk("bubble_ack", ACKOUT, 0);
    chk("bubble_head", DOUT, 8'h02);
    tick();
    chk("late_wr_level", LEVEL, 4);
    chk("late_wr_ack", ACKOUT, 1);
    SENDIN = 1'b0;
    for (int i = 0; i < 20 && ACKOUT; i++) tick();
    chk("bp_ack_fall", ACKOUT, 0);
    for (int i = 2; i <= 5; i++) pop(8'(i));
    chk("fill_drained", LEVEL, 0);

    DREADY = 1'b1;
    mon = 1'b1;
    for (int i = 0; i < 10; i++) send(8'(i));
    tick();
    mon = 1'b0;
    DREADY = 1'b0;
    chk("wrap_count", q.size(), 10);
    for (int i = 0; i < 10; i++) chk("wrap_order", (i < q.size()) ? q[i] : 8'hFF, 8'(i));
    chk("wrap_maxlvl", max_lvl, 1);
    chk("wrap_level", LEVEL, 0);

    send(8'h20);
    send(8'h21);
    chk("sim_pre_level", LEVEL, 2);
    DIN = 8'h22;
    SENDIN = 1'b1;
    tick();
    tick();
    DREADY = 1'b1;
    tick();
    DREADY = 1'b0;
    chk("sim_level", LEVEL, 2);
    chk("sim_ack", ACKOUT, 1);
    SENDIN = 1'b0;
    for (int i = 0; i < 20 && ACKOUT; i++) tick();
    chk("sim_ack_fall", ACKOUT, 0);
    pop(8'h21);
    pop(8'h22);
    chk("sim_drained", LEVEL, 0);

    send(8'h30);
    send(8'h31);
    DIN = 8'h32;
    SENDIN = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_ack", ACKOUT, 1);
    chk("mid_level", LEVEL, 3);
    RESETN = 1'b0;
    SENDIN = 1'b0;
    tick();
    chk("mrst_ack", ACKOUT, 0);
    chk("mrst_valid", DVALID, 0);
    chk("mrst_level", LEVEL, 0);
`ifdef CUES_SINK_TOKEN_CNT_EN
    chk("mrst_tok", TOKCNT, 0);
`endif
    RESETN = 1'b1;
    tick();
    send(8'h40);
    chk("post_rst_level", LEVEL, 1);
    chk("post_rst_dout", DOUT, 8'h40);
`ifdef CUES_SINK_TOKEN_CNT_EN
    chk("post_rst_tok", TOKCNT, 1);
`endif
    pop(8'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cues_sync_sink.md
Name: cues_sync_sink

Overview:
- Clocked terminal receiver for a self-timed C-element pipeline. Sits at the downstream end of the last stage, replacing the next C-element.
- Accepts bundled-data tokens on the 4-phase SENDIN/ACKOUT handshake and stores them in a small FIFO.
- Presents the tokens to synchronous logic through a valid/ready interface.

Parameters:
- DW, 8, token data width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, flops in the SENDIN synchronizer; at least 2.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESETN  input  1  reset, synchronous and active-low.
- SENDIN  input  1  asynchronous request from the last stage's SENDOUT.
- DIN  input  DW  bundled data; stable before SENDIN rises, held until ACKOUT rises.
- ACKOUT  output  1  acknowledge to the last stage's ACKIN; registered.
- DOUT  output  DW  FIFO head data.
- DVALID  output  1  FIFO non-empty.
- DREADY  input  1  consumer accepts DOUT when DVALID and DREADY are both 1 at a rising edge.
- LEVEL  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (RESETN=0 at an edge):
  - ACKOUT=0, DVALID=0, LEVEL=0, state=IDLE.
  - Synchronizer flops cleared; read and write pointers cleared.
  - DOUT value is don't-care while DVALID=0.
- Synchronizer: SYNC_STAGES-flop chain on SENDIN produces s_send. DIN is never synchronized; the bundled-data constraint guarantees it is stable.
- Protocol: 4-phase return-to-zero. SENDIN rises, ACKOUT rises, SENDIN falls, ACKOUT falls.
- FSM, 2 states:
  - IDLE: if s_send=1 and FIFO not full: write DIN at the write pointer, ACKOUT<=1, go to ACK.
  - IDLE: if s_send=1 and FIFO full: hold with ACKOUT=0. This stalls the upstream pipeline and is the backpressure path.
  - ACK: if s_send=0: ACKOUT<=0, go to IDLE. Otherwise hold ACKOUT=1.
  - No token is accepted while in ACK, so each SENDIN pulse produces exactly one write.
- Latency with SYNC_STAGES=2:
  - SENDIN rises before edge 1; s_send=1 after edge 2.
  - Edge 3 writes the token and sets ACKOUT=1; DVALID=1 is visible after edge 3.
  - SENDIN falling before edge k gives ACKOUT=0 after edge k+2.
  - General case: SYNC_STAGES+1 edges per transition.
- FIFO:
  - Circular buffer with pointer wrap at DEPTH. Full when LEVEL=DEPTH; empty when LEVEL=0.
  - Read pops when DVALID and DREADY are both 1.
  - DOUT is combinational from the head entry.
- Simultaneous write and read in one cycle (FIFO not full, not empty): both occur and LEVEL is unchanged.
- FIFO full with a pop in the same cycle: the write is NOT accepted that cycle; it is accepted on the next edge (one-cycle bubble).
- Empty FIFO: a pop is ignored, since DVALID=0.
- DREADY=1 with no data pending: no effect.
- Reset mid-handshake:
  - ACKOUT drops and any stored tokens are discarded.
  - RESETN is shared with the C-element pipeline, so the upstream stage is reset in the same cycle. SENDIN held high through reset is a system error and is not covered.
- Overflow of LEVEL is impossible by construction. Asserting DREADY after a pop has no side effect.

Optional Feature:
- Macro: CUES_SINK_TOKEN_CNT_EN.
- When defined:
  - Adds output TOKCNT[15:0].
  - Reset value 0; increments by 1 on every accepted write; wraps from 65535 to 0.
  - A write and a reset in the same cycle give TOKCNT=0.
- When undefined: the port and the counter are absent, and behaviour is otherwise identical.

Test Plan:
- Single token: DIN=8'hA5, SENDIN raised mid-cycle, DREADY=0 -> ACKOUT=1 and DVALID=1 after 3 edges, DOUT=8'hA5, LEVEL=1. Dropping SENDIN -> ACKOUT=0 after 3 edges.
- Fill/backpressure: 5 tokens 01..05, DREADY=0, DEPTH=4 -> tokens 01..04 acknowledged, LEVEL=4. Token 05 leaves ACKOUT low indefinitely. One pop with DREADY=1 -> DOUT=01 consumed; 05 is accepted on the following edge and LEVEL returns to 4.
- Order and wrap: 10 tokens 00..09 with DREADY=1 -> DOUT sequence is 00..09 in order across two pointer wraps; LEVEL never exceeds 1.
- Simultaneous write and pop at LEVEL=2 -> LEVEL stays 2 and data order is preserved.
- Reset mid-handshake: RESETN=0 while ACKOUT=1 and LEVEL=3 -> after that edge ACKOUT=0, DVALID=0, LEVEL=0. With the macro defined, TOKCNT=0.
- Counter wrap (macro defined): preload via 65536 accepted tokens -> TOKCNT reads 0. A single further token -> TOKCNT=1.
